prbs_checker: RTL and testbench
===============================

# prbs_checker

Serial receive-side checker for the team's Fibonacci LFSR pattern generator. It self-synchronises to an incoming PRBS bit stream, declares lock after a run of correct predictions, then free-runs a local LFSR and flags and counts every mismatching bit. It sits at the far end of a link or loopback path driven by the LFSR generator and reports link integrity to status LEDs or a host register.

## Interface
- WIDTH, 4, LFSR length in bits (2..16).
- TAP_HI, 3, upper feedback tap index. Generator feedback is sr[TAP_HI] ^ sr[TAP_LO].
- TAP_LO, 2, lower feedback tap index. Defaults give x^4+x^3+1, period 15.
- LOCK_CNT, 8, consecutive correct predictions required to declare lock (1..255).
- UNLOCK_ERRS, 3, consecutive mismatches while locked that force loss of lock (1..15).
- ERR_W, 16, error counter width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  received stream bit, in generator output order.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching bit while locked.
- err_count  out  ERR_W  saturating count of mismatches while locked.

## Operation
- State register sr[WIDTH-1:0]. Prediction is pred = sr[TAP_HI] ^ sr[TAP_LO]. Every shift is sr <= {sr[WIDTH-2:0], b}, which matches the generator (new bit into bit 0).
- FSM states: FILL, HUNT, LOCKED. Only cycles with in_valid=1 advance anything. When in_valid=0, all state holds and err_pulse=0.
- FILL:
  - Shift in in_bit. fill_cnt increments.
  - After WIDTH valid bits, go to HUNT with match_cnt=0.
  - No comparisons are made in FILL.
- HUNT:
  - Compare in_bit with pred, then shift in in_bit (self-synchronising).
  - Match with sr != 0: match_cnt increments.
  - Mismatch, or sr == 0 (zero-lock guard): match_cnt=0.
  - When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
  - err_count and err_pulse are not affected in HUNT.
- LOCKED:
  - Shift in pred, not in_bit (local free-run), so a single bit error does not propagate.
  - Mismatch: err_pulse=1, err_count increments (saturates at all-ones, never wraps), miss_cnt increments.
  - Match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_ERRS, go to FILL with fill_cnt=0. The bit that causes this still counts as an error.
- clr_cnt=1 sets err_count to 0 and takes priority over a simultaneous increment. err_pulse still fires.
- Reset (asynchronous, any time, including mid-lock): state=FILL, sr=0, all counters=0, locked=0, err_pulse=0, err_count=0.

## Timing
- All outputs are registered.
- locked rises on the clock edge that accepts the LOCK_CNT-th consecutive match.
  - From reset with a clean, continuous stream, that is the edge of valid bit WIDTH+LOCK_CNT (bit 12 with defaults).
- locked falls on the edge that accepts the UNLOCK_ERRS-th consecutive mismatch.
- err_pulse is high for exactly the one cycle after the edge sampling the bad bit. Back-to-back errors give back-to-back pulses.
- err_count updates on the same edge that sets err_pulse.
- Minimum time to regain lock after dropping it: WIDTH+LOCK_CNT valid bits.

## Test plan
Defaults throughout. Reference stream from generator seed 0001, one period: 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1, repeating.

- Reset, then the reference stream continuous for 60 bits -> locked=1 after bit 12 is sampled. err_pulse never asserts. err_count=0.
- Once locked, invert bit 20 -> a single err_pulse, err_count=1, locked stays 1. Subsequent correct bits produce no further errors.
- Once locked, invert bits 30, 31, 32 -> three err_pulses, err_count=3, locked=0 after bit 32. Clean stream afterwards -> locked=1 again 12 valid bits later.
- All-zero stream for 100 bits -> locked stays 0 (zero-lock guard), err_count=0.
- Reference stream with in_valid toggling 1,0,0,1… -> same lock point counted in valid bits only. Idle cycles change nothing.
- Force err_count to all-ones via repeated single errors -> it holds at 16'hFFFF. Assert clr_cnt together with an error -> err_count=0, err_pulse=1. Assert rst low mid-lock -> locked, err_count and err_pulse are 0 immediately (asynchronous).

Source files
------------

// File: rtl/prbs_checker_if.sv
// Link-side signal bundle for the PRBS checker: stream input, counter clear
// and the status outputs. The driver of the stream uses master, the checker
// uses slave.
interface prbs_checker_if #(
    parameter int ERR_W = 16
) ();
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_bit,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising receive checker for the Fibonacci LFSR pattern generator.
// Loads the shift register from the incoming stream, hunts for a run of
// correct predictions, then free-runs a local copy and counts bit errors.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FILL   | loading WIDTH received bits into sr, no comparisons
// S_HUNT   | predicting each bit, reloading sr from the stream, counting hits
// S_LOCKED | free-running sr on its own prediction, flagging every mismatch
//
// rst is active low and asynchronous.
module prbs_checker #(
    parameter int WIDTH       = 4,
    parameter int TAP_HI      = 3,
    parameter int TAP_LO      = 2,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_HUNT,
        S_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [UW-1:0]    miss_q, miss_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             locked_q;
    logic             pred;
    logic             mismatch;
    logic             sr_zero;

    assign pred     = sr_q[TAP_HI] ^ sr_q[TAP_LO];
    assign mismatch = bus.in_bit ^ pred;
    assign sr_zero  = (sr_q == '0);

    // Next-state, shift-register and counter update; only valid bits advance anything.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                S_FILL: begin
                    sr_d   = {sr_q[WIDTH-2:0], bus.in_bit};
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FW'(WIDTH - 1)) begin
                        state_d = S_HUNT;
                        match_d = '0;
                    end
                end
                S_HUNT: begin
                    sr_d = {sr_q[WIDTH-2:0], bus.in_bit};
                    // An all-zero register predicts zeros forever, so it never earns credit.
                    if (!mismatch && !sr_zero) begin
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = S_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    // Shift the prediction, not the received bit, so one bad bit stays one error.
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        miss_d  = miss_q + UW'(1);
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                        if (miss_q == UW'(UNLOCK_ERRS - 1)) begin
                            state_d = S_FILL;
                            fill_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = S_FILL;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment; the error pulse is unaffected.
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FILL;
            sr_q     <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            locked_q <= (state_d == S_LOCKED);
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a vector table for the lock sequence, hand-written
// corner sequences and a randomized run, all compared against a bit-history
// reference model. A second instance with a 4-bit counter exposes saturation.
`timescale 1ns/1ps
module tb_prbs_checker;

    localparam int WIDTH       = 4;
    localparam int TAP_HI      = 3;
    localparam int TAP_LO      = 2;
    localparam int LOCK_CNT    = 8;
    localparam int UNLOCK_ERRS = 3;
    localparam int ERR_W       = 16;
    localparam int ERR_WS      = 4;

    localparam int M_FILL = 0;
    localparam int M_HUNT = 1;
    localparam int M_LOCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    prbs_checker_if #(.ERR_W(ERR_W))  bus ();
    prbs_checker_if #(.ERR_W(ERR_WS)) bus_s ();

    prbs_checker #(
        .WIDTH(WIDTH), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    prbs_checker #(
        .WIDTH(WIDTH), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(ERR_WS)
    ) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(bus_s)
    );

    int errors = 0;
    int checks = 0;

    // One period of the generator output from seed 0001.
    int refp [15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int gidx;

    // Reference model: history of effective bits, newest at index 0.
    bit m_hist [WIDTH];
    int m_mode;
    int m_fill;
    int m_match;
    int m_miss;
    int m_cnt;
    int m_cnt_s;
    bit m_pulse;

    typedef struct {
        bit v;
        bit flip;
        bit c;
        bit e_lock;
        bit e_pulse;
        int e_cnt;
    } vec_t;

    vec_t tbl [18];

    function automatic int sat_inc(input int v, input int w);
        return (v == (1 << w) - 1) ? v : v + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < WIDTH; k++) m_hist[k] = 1'b0;
        m_mode  = M_FILL;
        m_fill  = 0;
        m_match = 0;
        m_miss  = 0;
        m_cnt   = 0;
        m_cnt_s = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p;
        bit allz;
        bit nb;
        m_pulse = 1'b0;
        if (v) begin
            p    = m_hist[TAP_HI] ^ m_hist[TAP_LO];
            allz = 1'b1;
            for (int k = 0; k < WIDTH; k++) if (m_hist[k]) allz = 1'b0;
            nb = b;
            if (m_mode == M_FILL) begin
                m_fill++;
                if (m_fill == WIDTH) begin
                    m_mode  = M_HUNT;
                    m_match = 0;
                end
            end else if (m_mode == M_HUNT) begin
                if (b == p && !allz) m_match++;
                else m_match = 0;
                if (m_match == LOCK_CNT) begin
                    m_mode = M_LOCK;
                    m_miss = 0;
                end
            end else begin
                nb = p;
                if (b != p) begin
                    m_pulse = 1'b1;
                    m_cnt   = sat_inc(m_cnt, ERR_W);
                    m_cnt_s = sat_inc(m_cnt_s, ERR_WS);
                    m_miss++;
                    if (m_miss == UNLOCK_ERRS) begin
                        m_mode = M_FILL;
                        m_fill = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
            for (int k = WIDTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = nb;
        end
        if (c) begin
            m_cnt   = 0;
            m_cnt_s = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit el;
        el = (m_mode == M_LOCK);
        checks++;
        if (bus.locked !== el || bus.err_pulse !== m_pulse ||
            bus.err_count !== 16'(m_cnt) || bus_s.locked !== el ||
            bus_s.err_pulse !== m_pulse || bus_s.err_count !== 4'(m_cnt_s)) begin
            errors++;
            $display("FAIL model t=%0t: locked %b want %b, pulse %b want %b, count %0d want %0d, small count %0d want %0d",
                     $time, bus.locked, el, bus.err_pulse, m_pulse,
                     bus.err_count, m_cnt, bus_s.err_count, m_cnt_s);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit c);
        bus.in_valid   = v;
        bus.in_bit     = b;
        bus.clr_cnt    = c;
        bus_s.in_valid = v;
        bus_s.in_bit   = b;
        bus_s.clr_cnt  = c;
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        drive(v, b, c);
        @(posedge clk);
        #1;
        model_step(v, b, c);
        check_model();
    endtask

    // Next stream bit (optionally inverted) on valid cycles; junk on idle ones.
    task automatic send(input bit v, input bit flip, input bit c);
        bit b;
        if (v) begin
            b = bit'(refp[gidx % 15]) ^ flip;
            gidx++;
        end else begin
            b = bit'($urandom_range(0, 1));
        end
        step(v, b, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_locked", int'(bus.locked), 0);
        chk("reset_pulse", int'(bus.err_pulse), 0);
        chk("reset_count", int'(bus.err_count), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        gidx = 0;
    endtask

    initial begin
        int nv;
        bit seen;
        int burst;
        bit v;
        bit f;
        bit c;

        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        gidx = 0;

        // Lock sequence from reset with one idle cycle, then an error and a clear.
        nv = 0;
        for (int i = 0; i < 18; i++) begin
            tbl[i].v    = (i != 5) && (i != 17);
            tbl[i].flip = (i == 15);
            tbl[i].c    = (i == 17);
            if (tbl[i].v) nv++;
            tbl[i].e_lock  = (nv >= WIDTH + LOCK_CNT);
            tbl[i].e_pulse = (i == 15);
            tbl[i].e_cnt   = (i == 15 || i == 16) ? 1 : 0;
        end

        do_reset();
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].v, tbl[i].flip, tbl[i].c);
            checks++;
            if (bus.locked !== tbl[i].e_lock || bus.err_pulse !== tbl[i].e_pulse ||
                bus.err_count !== 16'(tbl[i].e_cnt)) begin
                errors++;
                $display("FAIL vec%0d: locked=%b pulse=%b count=%0d expected %b %b %0d",
                         i, bus.locked, bus.err_pulse, bus.err_count,
                         tbl[i].e_lock, tbl[i].e_pulse, tbl[i].e_cnt);
            end
        end

        // Clean 60-bit stream: no pulses ever.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (bus.err_pulse) seen = 1'b1;
        end
        chk("clean_pulse_seen", int'(seen), 0);
        chk("clean_locked", int'(bus.locked), 1);
        chk("clean_count", int'(bus.err_count), 0);

        // Single error at bit 20, then a triple at 30..32 and relock.
        do_reset();
        for (int n = 1; n <= 50; n++) begin
            send(1'b1, (n == 20 || n == 30 || n == 31 || n == 32), 1'b0);
            if (n == 20) begin
                chk("single_pulse", int'(bus.err_pulse), 1);
                chk("single_count", int'(bus.err_count), 1);
                chk("single_locked", int'(bus.locked), 1);
            end
            if (n == 21) chk("single_no_repeat", int'(bus.err_pulse), 0);
            if (n == 31) chk("triple_still_locked", int'(bus.locked), 1);
            if (n == 32) begin
                chk("triple_unlock", int'(bus.locked), 0);
                chk("triple_count", int'(bus.err_count), 4);
                chk("triple_pulse", int'(bus.err_pulse), 1);
            end
            if (n == 43) chk("relock_early", int'(bus.locked), 0);
            if (n == 44) chk("relock", int'(bus.locked), 1);
        end

        // All-zero stream never locks.
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.locked) seen = 1'b1;
        end
        chk("zero_never_locked", int'(seen), 0);
        chk("zero_count", int'(bus.err_count), 0);

        // valid pattern 1,0,0: lock point counted in valid bits only.
        do_reset();
        nv = 0;
        for (int i = 0; i < 45; i++) begin
            v = (i % 3 == 0);
            send(v, 1'b0, 1'b0);
            if (v) begin
                nv++;
                if (nv == 11) chk("gap_lock_early", int'(bus.locked), 0);
                if (nv == 12) chk("gap_lock", int'(bus.locked), 1);
            end
        end

        // Saturation on the 4-bit instance, clear-with-error, async reset mid-lock.
        do_reset();
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) send(1'b1, 1'b0, 1'b0);
        end
        chk("sat_small_count", int'(bus_s.err_count), 15);
        chk("sat_main_count", int'(bus.err_count), 20);
        chk("sat_locked", int'(bus_s.locked), 1);
        send(1'b1, 1'b1, 1'b1);
        chk("clr_err_count", int'(bus.err_count), 0);
        chk("clr_err_pulse", int'(bus.err_pulse), 1);
        chk("clr_small_count", int'(bus_s.err_count), 0);
        send(1'b1, 1'b1, 1'b0);
        chk("pre_rst_pulse", int'(bus.err_pulse), 1);
        chk("pre_rst_locked", int'(bus.locked), 1);
        rst = 1'b0;
        #1;
        chk("async_locked", int'(bus.locked), 0);
        chk("async_pulse", int'(bus.err_pulse), 0);
        chk("async_count", int'(bus.err_count), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        gidx = 0;

        // Randomized: idle gaps, sparse errors, occasional bursts and clears.
        do_reset();
        gidx  = $urandom_range(0, 14);
        burst = 0;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 8);
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(2, 4);
            f = v && (burst > 0 || $urandom_range(0, 99) < 4);
            if (v && burst > 0) burst--;
            c = ($urandom_range(0, 59) == 0);
            send(v, f, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
